// File: rtl/serial_mod_pkg.sv
// Shared widths, defaults and modular helpers for the serial divisibility checker.
package serial_mod_pkg;

    localparam int DEF_DIVISOR   = 3;
    localparam int DEF_LSB_FIRST = 0;
    localparam int DEF_CNT_W     = 16;
    localparam int MOD_W         = 9;

    function automatic int rem_width(input int divisor);
        int w;
        w = 0;
        for (int i = 0; i < MOD_W; i++) begin
            if ((1 << i) < divisor) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Operands must satisfy a + b < 2*divisor so one subtract suffices.
    function automatic logic [MOD_W-1:0] mod_add(
        input logic [MOD_W-1:0] a,
        input logic [MOD_W-1:0] b,
        input logic [MOD_W-1:0] divisor
    );
        logic [MOD_W-1:0] s;
        s = a + b;
        return (s >= divisor) ? (s - divisor) : s;
    endfunction

endpackage

// File: rtl/mod_n_step.sv
// One serial modular step: folds a single bit into a remainder.
module mod_n_step
    import serial_mod_pkg::*;
#(
    parameter int DIVISOR = DEF_DIVISOR,
    localparam int REM_W  = rem_width(DIVISOR)
) (
    input  logic [REM_W-1:0] base_rem,
    input  logic [REM_W-1:0] base_weight,
    input  logic             data_bit,
    input  logic             lsb_first,
    output logic [REM_W-1:0] next_rem,
    output logic [REM_W-1:0] next_weight
);

    localparam logic [MOD_W-1:0] DIV_M = MOD_W'(DIVISOR);

    always_comb begin
        next_rem    = '0;
        next_weight = '0;
        if (lsb_first) begin
            next_rem = REM_W'(mod_add(
                MOD_W'(base_rem),
                data_bit ? MOD_W'(base_weight) : '0,
                DIV_M));
            next_weight = REM_W'(mod_add(
                MOD_W'(base_weight),
                MOD_W'(base_weight),
                DIV_M));
        end else begin
            next_rem = REM_W'(mod_add(
                MOD_W'({base_rem, data_bit}),
                '0,
                DIV_M));
            next_weight = base_weight;
        end
    end

endmodule

// File: rtl/serial_mod_checker.sv
// Framed serial divisibility checker with running and per-number results.
module serial_mod_checker
    import serial_mod_pkg::*;
#(
    parameter int DIVISOR   = DEF_DIVISOR,
    parameter bit LSB_FIRST = 1'(DEF_LSB_FIRST),
    parameter int CNT_W     = DEF_CNT_W,
    localparam int REM_W    = rem_width(DIVISOR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    input  logic             sop_i,
    input  logic             eop_i,
    output logic [REM_W-1:0] rem_o,
    output logic             div_o,
    output logic [CNT_W-1:0] bit_cnt_o,
    output logic             result_valid_o,
    output logic             result_div_o,
    output logic [REM_W-1:0] result_rem_o
);

    if (DIVISOR < 2 || DIVISOR > 255) begin : g_bad_divisor
        $error("serial_mod_checker: DIVISOR must be in 2..255");
    end

    localparam logic [REM_W-1:0] ONE = REM_W'(1);

    logic [REM_W-1:0] rem_q, weight_q;
    logic [REM_W-1:0] base_rem, base_weight;
    logic [REM_W-1:0] next_rem, next_weight, weight_d;
    logic [CNT_W-1:0] cnt_q, base_cnt, cnt_d;
    logic             fresh_q, div_q;
    logic             res_valid_q, res_div_q;
    logic [REM_W-1:0] res_rem_q;
    logic             restart;

    // A finished number stays visible until the next beat restarts from base.
    always_comb begin
        restart     = sop_i | fresh_q;
        base_rem    = restart ? '0  : rem_q;
        base_weight = restart ? ONE : weight_q;
        base_cnt    = restart ? '0  : cnt_q;
        cnt_d       = (&base_cnt) ? base_cnt : base_cnt + CNT_W'(1);
        weight_d    = LSB_FIRST ? next_weight : ONE;
    end

    mod_n_step #(
        .DIVISOR(DIVISOR)
    ) u_step (
        .base_rem   (base_rem),
        .base_weight(base_weight),
        .data_bit   (bit_i),
        .lsb_first  (LSB_FIRST),
        .next_rem   (next_rem),
        .next_weight(next_weight)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q       <= '0;
            weight_q    <= ONE;
            cnt_q       <= '0;
            div_q       <= 1'b1;
            fresh_q     <= 1'b1;
            res_valid_q <= 1'b0;
            res_div_q   <= 1'b0;
            res_rem_q   <= '0;
        end else begin
            res_valid_q <= 1'b0;
            if (bit_valid_i) begin
                rem_q    <= next_rem;
                weight_q <= weight_d;
                cnt_q    <= cnt_d;
                div_q    <= (next_rem == '0);
                fresh_q  <= eop_i;
                if (eop_i) begin
                    res_valid_q <= 1'b1;
                    res_div_q   <= (next_rem == '0);
                    res_rem_q   <= next_rem;
                end
            end
        end
    end

    assign rem_o          = rem_q;
    assign div_o          = div_q;
    assign bit_cnt_o      = cnt_q;
    assign result_valid_o = res_valid_q;
    assign result_div_o   = res_div_q;
    assign result_rem_o   = res_rem_q;

endmodule

// File: doc/serial_mod_checker.md
Name: serial_mod_checker

Overview:
- Parametrised serial divisibility checker. Consumes a binary number one bit per accepted beat and tracks its remainder modulo DIVISOR.
- Supports MSB-first or LSB-first bit order, valid-qualified input, and framing: sop_i starts a number, eop_i ends it.
- Produces a running remainder/divisible flag and a per-number result pulse.
- Sits downstream of serial bit sources in the QuickSilicon problem set. Successor to the fixed divide-by-3 remainder FSM.

Parameters:
- DIVISOR, 3, modulus; legal range 2..255; elaboration error outside this range.
- LSB_FIRST, 0, 0 = bits arrive MSB first; 1 = bits arrive LSB first.
- CNT_W, 16, width of the accepted-bit counter; counter saturates at all-ones.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- bit_valid_i  input  1  bit_i/sop_i/eop_i are meaningful this cycle
- bit_i  input  1  serial data bit
- sop_i  input  1  first bit of a new number (qualified by bit_valid_i)
- eop_i  input  1  last bit of current number (qualified by bit_valid_i)
- rem_o  output  REM_W  running remainder, REM_W = $clog2(DIVISOR)
- div_o  output  1  running flag, rem_o == 0
- bit_cnt_o  output  CNT_W  bits accepted in current number, saturating
- result_valid_o  output  1  one-cycle pulse: a number completed
- result_div_o  output  1  divisibility of last completed number; held until next result
- result_rem_o  output  REM_W  remainder of last completed number; held

Behaviour:
- Reset (synchronous, active-high): rem=0, weight=1, bit_cnt=0, div_o=1, result_valid_o=0, result_div_o=0, result_rem_o=0. Reset wins over every other input in the same cycle.
- A beat is accepted on a rising edge where bit_valid_i=1. With bit_valid_i=0, all state holds; sop_i, eop_i and bit_i are ignored.
- Base values: if sop_i=1 on an accepted beat, the update uses base rem=0, weight=1, cnt=0. Otherwise it uses the current registers. A mid-number sop_i silently abandons the current number; no result pulse is issued for it.
- MSB-first update: rem' = (2*rem + bit) mod DIVISOR.
- LSB-first update:
  - rem' = (rem + (bit ? weight : 0)) mod DIVISOR
  - weight' = (2*weight) mod DIVISOR, where the base weight is 1.
- Every modular step must be a single conditional subtract (operand < 2*DIVISOR). No divider or `%` operator. Intermediates are REM_W+1 bits wide.
- bit_cnt' = base_cnt + 1, saturating at 2^CNT_W-1.
- Outputs are registered. rem_o, div_o and bit_cnt_o reflect all beats accepted up to and including the previous edge (latency 1).
- eop_i on an accepted beat:
  - The next cycle pulses result_valid_o=1.
  - result_rem_o takes the updated rem'.
  - result_div_o takes (rem'==0).
  - Running state then restarts: rem=0, weight=1, cnt=0. The next number therefore needs no sop_i.
- sop_i=1 and eop_i=1 on the same beat form a one-bit number; the result is produced from base values plus that bit.
- Back-to-back numbers (eop on cycle N, next bit on cycle N+1) are sustained at full rate.
- Before any bit arrives, div_o=1 (the empty number is divisible).
- The weight register exists only when LSB_FIRST=1; it is optimised away otherwise.
- Reset mid-number discards the partial number and emits no result.

Decomposition:
- Package serial_mod_pkg:
  - function rem_width(divisor)
  - function mod_add(a, b, divisor) — conditional-subtract helper
  - localparam defaults
- One sub-module, mod_n_step (combinational):
  - Inputs: base rem, base weight, bit, mode.
  - Outputs: next rem, next weight.
  - Instantiated once; unit-testable on its own.

Test Plan:
- DIVISOR=3, MSB-first, sop on first beat, bits 1,1,0 (=6), eop on last → rem_o 1,0,0; result_valid_o pulse with result_div_o=1, result_rem_o=0; bit_cnt_o=3 before restart.
- DIVISOR=5, LSB_FIRST=1, bits 1,0,1,1 (=13) → rem_o 1,1,0,3; result_rem_o=3, result_div_o=0.
- DIVISOR=7, MSB-first, bits 1,1,1,0 (=14) with bit_valid_i low for 2 cycles between beats → rem_o 1,3,0,0, held during gaps; result_div_o=1.
- DIVISOR=3: bits 1,0 then sop with bits 1,1 (=3), eop → no pulse for abandoned number; single pulse with result_div_o=1.
- sop+eop same beat with bit 0, then next cycle a one-bit number with bit 1 → two consecutive pulses: result_div_o 1 then 0.
- Reset asserted mid-number after bits 1,0 (DIVISOR=3) → next edge rem_o=0, div_o=1, bit_cnt_o=0, no result pulse. CNT_W=3: 9 bits of zeros → bit_cnt_o saturates at 7.
